// File: rtl/icache_fetch_adapter.sv
// Fetch-side adapter between the instruction fetch unit and the icache: tracks outstanding
// requests, drops responses for killed fetches and selects the requested word from each line.
// Define ICACHE_LINE_BUFFER_EN to add a one-entry line buffer that serves same-line fetches.
module icache_fetch_adapter #(
  parameter int unsigned ADDR_WIDTH  = 40,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned FETCH_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  fetch_req_vaddr_i,
  output logic                   fetch_req_ready_o,
  input  logic                   fetch_kill_i,
  input  logic                   fetch_inval_i,
  output logic                   fetch_resp_valid_o,
  output logic [FETCH_WIDTH-1:0] fetch_resp_data_o,
  output logic [ADDR_WIDTH-1:0]  fetch_resp_vaddr_o,
  output logic                   fetch_resp_xcpt_o,
  output logic                   icache_req_valid_o,
  output logic [ADDR_WIDTH-1:0]  icache_req_vaddr_o,
  input  logic                   icache_req_ready_i,
  output logic                   icache_req_kill_o,
  output logic                   icache_invalidate_o,
  input  logic                   icache_resp_valid_i,
  input  logic [LINE_WIDTH-1:0]  icache_resp_data_i,
  input  logic                   icache_resp_xcpt_i,
  output logic                   buffer_miss_o
);

  localparam int unsigned WOff  = $clog2(FETCH_WIDTH / 8);
  localparam int unsigned Words = LINE_WIDTH / FETCH_WIDTH;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned PtrW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  fifo_q [QUEUE_DEPTH];
  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CntW-1:0]        drop_q, drop_d;
  logic                   resp_valid_q, resp_xcpt_q;
  logic [FETCH_WIDTH-1:0] resp_data_q;
  logic [ADDR_WIDTH-1:0]  resp_vaddr_q;

  logic [CntW:0]          outstanding;
  logic                   q_full, buf_hit, hit_take, icache_push, resp_take, resp_drop;
  logic [ADDR_WIDTH-1:0]  head_vaddr;
  logic [FETCH_WIDTH-1:0] hit_word;

  function automatic logic [FETCH_WIDTH-1:0] word_sel(input logic [LINE_WIDTH-1:0] line,
                                                      input logic [ADDR_WIDTH-1:0] vaddr);
    logic [IdxW-1:0] idx;
    idx = IdxW'((vaddr >> WOff) & ADDR_WIDTH'(Words - 1));
    return line[idx*FETCH_WIDTH +: FETCH_WIDTH];
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Dropped-but-pending responses still occupy icache slots, so they count against the limit.
  assign outstanding = {1'b0, cnt_q} + {1'b0, drop_q};
  assign q_full      = outstanding >= (CntW + 1)'(QUEUE_DEPTH);
  assign head_vaddr  = fifo_q[rd_ptr_q];

`ifdef ICACHE_LINE_BUFFER_EN
  localparam int unsigned Off  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TagW = ADDR_WIDTH - Off;

  logic                  buf_valid_q;
  logic [TagW-1:0]       buf_tag_q;
  logic [LINE_WIDTH-1:0] buf_data_q;

  assign buf_hit  = fetch_req_valid_i & buf_valid_q &
                    (buf_tag_q == fetch_req_vaddr_i[ADDR_WIDTH-1:Off]) &
                    (cnt_q == '0) & (drop_q == '0);
  assign hit_word = word_sel(buf_data_q, fetch_req_vaddr_i);

  // Invalidate wins over a same-cycle fill so fence.i never leaves stale code behind.
  always_ff @(posedge clk_i) begin
    if (rst_i || fetch_inval_i) begin
      buf_valid_q <= 1'b0;
    end else if (resp_take && !icache_resp_xcpt_i) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= head_vaddr[ADDR_WIDTH-1:Off];
      buf_data_q  <= icache_resp_data_i;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign hit_word = '0;
`endif

  assign icache_req_valid_o  = ~rst_i & fetch_req_valid_i & ~fetch_kill_i & ~buf_hit & ~q_full;
  assign icache_req_vaddr_o  = rst_i ? '0 : fetch_req_vaddr_i;
  assign fetch_req_ready_o   = ~rst_i & ~fetch_kill_i &
                               (buf_hit | (icache_req_ready_i & ~q_full));
  assign icache_push         = icache_req_valid_o & icache_req_ready_i;
  assign hit_take            = ~rst_i & buf_hit & ~fetch_kill_i;
  assign buffer_miss_o       = icache_push;
  assign icache_req_kill_o   = ~rst_i & fetch_kill_i;
  assign icache_invalidate_o = ~rst_i & fetch_inval_i;

  assign resp_take = icache_resp_valid_i & ~fetch_kill_i & (state_q == StBusy);
  assign resp_drop = icache_resp_valid_i & (state_q == StDrain);

  always_comb begin
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (fetch_kill_i) begin
      // Everything in flight becomes a drop, minus a response consumed this very cycle.
      cnt_d  = '0;
      drop_d = drop_q + cnt_q - CntW'(icache_resp_valid_i && (state_q != StIdle));
    end else begin
      if (resp_drop) begin
        drop_d = drop_q - CntW'(1);
      end
      cnt_d = cnt_q + CntW'(icache_push) - CntW'(resp_take);
    end
  end

  always_ff @(posedge clk_i) begin
    if (icache_push) begin
      fifo_q[wr_ptr_q] <= fetch_req_vaddr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      drop_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_xcpt_q  <= 1'b0;
      resp_data_q  <= '0;
      resp_vaddr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      if (drop_d != '0) begin
        state_q <= StDrain;
      end else if (cnt_d != '0) begin
        state_q <= StBusy;
      end else begin
        state_q <= StIdle;
      end

      if (fetch_kill_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (icache_push) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (resp_take) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
      end

      resp_valid_q <= resp_take | hit_take;
      if (resp_take) begin
        resp_data_q  <= icache_resp_xcpt_i ? '0 : word_sel(icache_resp_data_i, head_vaddr);
        resp_vaddr_q <= head_vaddr;
        resp_xcpt_q  <= icache_resp_xcpt_i;
      end else if (hit_take) begin
        resp_data_q  <= hit_word;
        resp_vaddr_q <= fetch_req_vaddr_i;
        resp_xcpt_q  <= 1'b0;
      end
    end
  end

  assign fetch_resp_valid_o = ~rst_i & resp_valid_q;
  assign fetch_resp_data_o  = rst_i ? '0 : resp_data_q;
  assign fetch_resp_vaddr_o = rst_i ? '0 : resp_vaddr_q;
  assign fetch_resp_xcpt_o  = ~rst_i & resp_xcpt_q;

  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= (CntW + 1)'(QUEUE_DEPTH));
  a_single_resp_source: assert property (@(posedge clk_i) disable iff (rst_i)
    !(resp_take && hit_take));

endmodule

// File: tb/tb_icache_fetch_adapter.sv
// Self-checking bench for icache_fetch_adapter; responses are checked against a scoreboard
// of expected (vaddr, data, xcpt, cycle) entries pushed when the icache response is driven.
module tb_icache_fetch_adapter;

  localparam int unsigned AW = 40;
  localparam int unsigned LW = 128;
  localparam int unsigned FW = 32;
  localparam int unsigned QD = 2;

  localparam logic [LW-1:0] L1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [LW-1:0] L2 = 128'h44444444_33333333_22222222_11111111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req_valid_i, fetch_kill_i, fetch_inval_i;
  logic [AW-1:0] fetch_req_vaddr_i;
  logic          fetch_req_ready_o;
  logic          fetch_resp_valid_o, fetch_resp_xcpt_o;
  logic [FW-1:0] fetch_resp_data_o;
  logic [AW-1:0] fetch_resp_vaddr_o;
  logic          icache_req_valid_o, icache_req_ready_i, icache_req_kill_o, icache_invalidate_o;
  logic [AW-1:0] icache_req_vaddr_o;
  logic          icache_resp_valid_i, icache_resp_xcpt_i;
  logic [LW-1:0] icache_resp_data_i;
  logic          buffer_miss_o;

  typedef struct {
    logic [AW-1:0] vaddr;
    logic [FW-1:0] data;
    logic          xcpt;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  icache_fetch_adapter #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .FETCH_WIDTH(FW),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .fetch_req_valid_i  (fetch_req_valid_i),
    .fetch_req_vaddr_i  (fetch_req_vaddr_i),
    .fetch_req_ready_o  (fetch_req_ready_o),
    .fetch_kill_i       (fetch_kill_i),
    .fetch_inval_i      (fetch_inval_i),
    .fetch_resp_valid_o (fetch_resp_valid_o),
    .fetch_resp_data_o  (fetch_resp_data_o),
    .fetch_resp_vaddr_o (fetch_resp_vaddr_o),
    .fetch_resp_xcpt_o  (fetch_resp_xcpt_o),
    .icache_req_valid_o (icache_req_valid_o),
    .icache_req_vaddr_o (icache_req_vaddr_o),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_req_kill_o  (icache_req_kill_o),
    .icache_invalidate_o(icache_invalidate_o),
    .icache_resp_valid_i(icache_resp_valid_i),
    .icache_resp_data_i (icache_resp_data_i),
    .icache_resp_xcpt_i (icache_resp_xcpt_i),
    .buffer_miss_o      (buffer_miss_o)
  );

  always #5 clk = ~clk;

  // Response monitor: every fetch response must match the oldest expectation, on its cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #2;
    if (fetch_resp_valid_o === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: got vaddr=%h data=%h xcpt=%b at cycle %0d, required none",
                 fetch_resp_vaddr_o, fetch_resp_data_o, fetch_resp_xcpt_o, cyc);
      end else begin
        e = sb.pop_front();
        if (fetch_resp_vaddr_o !== e.vaddr || fetch_resp_data_o !== e.data ||
            fetch_resp_xcpt_o !== e.xcpt || cyc != e.cyc) begin
          n_err++;
          $display("FAIL resp_compare: got vaddr=%h data=%h xcpt=%b cyc=%0d, required vaddr=%h data=%h xcpt=%b cyc=%0d",
                   fetch_resp_vaddr_o, fetch_resp_data_o, fetch_resp_xcpt_o, cyc,
                   e.vaddr, e.data, e.xcpt, e.cyc);
        end
      end
    end
  end

  task automatic cycle(input logic rv, input logic [AW-1:0] a, input logic k, input logic inv,
                       input logic sv, input logic [LW-1:0] line, input logic x);
    @(negedge clk);
    fetch_req_valid_i   = rv;
    fetch_req_vaddr_i   = a;
    fetch_kill_i        = k;
    fetch_inval_i       = inv;
    icache_resp_valid_i = sv;
    icache_resp_data_i  = line;
    icache_resp_xcpt_i  = x;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    fetch_req_valid_i   = 1'b1;
    fetch_req_vaddr_i   = 40'h1234;
    fetch_kill_i        = 1'b1;
    fetch_inval_i       = 1'b1;
    icache_req_ready_i  = 1'b1;
    icache_resp_valid_i = 1'b1;
    icache_resp_data_i  = L1;
    icache_resp_xcpt_i  = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({fetch_req_ready_o, icache_req_valid_o, icache_req_kill_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_req_side: got ready/valid/kill=%b, required 000",
               {fetch_req_ready_o, icache_req_valid_o, icache_req_kill_o});
    end
    n_cmp++;
    if ({icache_invalidate_o, buffer_miss_o, fetch_resp_valid_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_misc: got inval/miss/resp_valid=%b, required 000",
               {icache_invalidate_o, buffer_miss_o, fetch_resp_valid_o});
    end
    n_cmp++;
    if (icache_req_vaddr_o !== '0) begin
      n_err++;
      $display("FAIL reset_icache_vaddr: got %h, required 0", icache_req_vaddr_o);
    end
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({fetch_resp_valid_o, fetch_resp_xcpt_o, fetch_resp_data_o, fetch_resp_vaddr_o} !== '0) begin
      n_err++;
      $display("FAIL reset_after_release: got resp valid=%b xcpt=%b data=%h vaddr=%h, required 0",
               fetch_resp_valid_o, fetch_resp_xcpt_o, fetch_resp_data_o, fetch_resp_vaddr_o);
    end
    // A response with nothing outstanding must be ignored.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    idle(1);
    n_cmp++;
    if (fetch_resp_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_spurious_resp: got resp_valid=%b, required 0", fetch_resp_valid_o);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 40'h1008, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, fetch_req_ready_o, buffer_miss_o} !== 3'b111) begin
      n_err++;
      $display("FAIL basic_accept: got valid/ready/miss=%b, required 111",
               {icache_req_valid_o, fetch_req_ready_o, buffer_miss_o});
    end
    n_cmp++;
    if (icache_req_vaddr_o !== 40'h1008) begin
      n_err++;
      $display("FAIL basic_icache_vaddr: got %h, required 1008", icache_req_vaddr_o);
    end
    idle(1);
    n_cmp++;
    if (buffer_miss_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_miss_pulse: got %b, required 0", buffer_miss_o);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    sb.push_back('{vaddr: 40'h1008, data: 32'hCCCCCCCC, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  task automatic test_line_buffer();
    cycle(1'b1, 40'h100C, 1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef ICACHE_LINE_BUFFER_EN
    n_cmp++;
    if ({icache_req_valid_o, fetch_req_ready_o, buffer_miss_o} !== 3'b010) begin
      n_err++;
      $display("FAIL buffer_hit: got valid/ready/miss=%b, required 010",
               {icache_req_valid_o, fetch_req_ready_o, buffer_miss_o});
    end
    sb.push_back('{vaddr: 40'h100C, data: 32'hDDDDDDDD, xcpt: 1'b0, cyc: cyc + 1});
`else
    n_cmp++;
    if ({icache_req_valid_o, fetch_req_ready_o, buffer_miss_o} !== 3'b111) begin
      n_err++;
      $display("FAIL no_buffer_miss: got valid/ready/miss=%b, required 111",
               {icache_req_valid_o, fetch_req_ready_o, buffer_miss_o});
    end
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    sb.push_back('{vaddr: 40'h100C, data: 32'hDDDDDDDD, xcpt: 1'b0, cyc: cyc + 1});
`endif
    idle(2);
  endtask

  task automatic test_kill();
    cycle(1'b1, 40'h2000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 40'h2010, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, fetch_req_ready_o} !== 2'b11) begin
      n_err++;
      $display("FAIL kill_second_req: got valid/ready=%b, required 11",
               {icache_req_valid_o, fetch_req_ready_o});
    end
    cycle(1'b1, 40'h2020, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_kill_o, fetch_req_ready_o, icache_req_valid_o} !== 3'b100) begin
      n_err++;
      $display("FAIL kill_outputs: got kill/ready/valid=%b, required 100",
               {icache_req_kill_o, fetch_req_ready_o, icache_req_valid_o});
    end
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    idle(1);
    n_cmp++;
    if (fetch_resp_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL kill_dropped_resp: got resp_valid=%b, required 0", fetch_resp_valid_o);
    end
    cycle(1'b1, 40'h3000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, buffer_miss_o} !== 2'b11) begin
      n_err++;
      $display("FAIL kill_next_req: got valid/miss=%b, required 11",
               {icache_req_valid_o, buffer_miss_o});
    end
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    sb.push_back('{vaddr: 40'h3000, data: 32'hAAAAAAAA, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  task automatic test_drain();
    cycle(1'b1, 40'h5000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 40'h6004, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, fetch_req_ready_o} !== 2'b11) begin
      n_err++;
      $display("FAIL drain_accept: got valid/ready=%b, required 11",
               {icache_req_valid_o, fetch_req_ready_o});
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L2, 1'b0);
    sb.push_back('{vaddr: 40'h6004, data: 32'h22222222, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  task automatic test_xcpt();
    cycle(1'b1, 40'h4000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b1);
    sb.push_back('{vaddr: 40'h4000, data: 32'h0, xcpt: 1'b1, cyc: cyc + 1});
    idle(1);
    cycle(1'b1, 40'h4004, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, buffer_miss_o} !== 2'b11) begin
      n_err++;
      $display("FAIL xcpt_rerequest: got valid/miss=%b, required 11",
               {icache_req_valid_o, buffer_miss_o});
    end
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    sb.push_back('{vaddr: 40'h4004, data: 32'hBBBBBBBB, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  task automatic test_full();
    cycle(1'b1, 40'h7000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 40'h7010, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if (fetch_req_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL full_second_ready: got %b, required 1", fetch_req_ready_o);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 40'h7020, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      n_cmp++;
      if ({fetch_req_ready_o, icache_req_valid_o, buffer_miss_o} !== 3'b000) begin
        n_err++;
        $display("FAIL full_stall[%0d]: got ready/valid/miss=%b, required 000", i,
                 {fetch_req_ready_o, icache_req_valid_o, buffer_miss_o});
      end
    end
    cycle(1'b1, 40'h7020, 1'b0, 1'b0, 1'b1, L2, 1'b0);
    sb.push_back('{vaddr: 40'h7000, data: 32'h11111111, xcpt: 1'b0, cyc: cyc + 1});
    n_cmp++;
    if (fetch_req_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_resp_cycle_ready: got %b, required 0", fetch_req_ready_o);
    end
    cycle(1'b1, 40'h7020, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({fetch_req_ready_o, icache_req_valid_o, buffer_miss_o} !== 3'b111) begin
      n_err++;
      $display("FAIL full_release: got ready/valid/miss=%b, required 111",
               {fetch_req_ready_o, icache_req_valid_o, buffer_miss_o});
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    sb.push_back('{vaddr: 40'h7010, data: 32'hAAAAAAAA, xcpt: 1'b0, cyc: cyc + 1});
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L2, 1'b0);
    sb.push_back('{vaddr: 40'h7020, data: 32'h11111111, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  task automatic test_inval();
    cycle(1'b1, 40'h8000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L2, 1'b0);
    sb.push_back('{vaddr: 40'h8000, data: 32'h11111111, xcpt: 1'b0, cyc: cyc + 1});
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (icache_invalidate_o !== 1'b1) begin
      n_err++;
      $display("FAIL inval_passthrough: got %b, required 1", icache_invalidate_o);
    end
    cycle(1'b1, 40'h8004, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, buffer_miss_o, icache_invalidate_o} !== 3'b110) begin
      n_err++;
      $display("FAIL inval_rerequest: got valid/miss/inval=%b, required 110",
               {icache_req_valid_o, buffer_miss_o, icache_invalidate_o});
    end
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L2, 1'b0);
    sb.push_back('{vaddr: 40'h8004, data: 32'h22222222, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  task automatic test_midreset();
    cycle(1'b1, 40'h9000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L1, 1'b0);
    idle(1);
    n_cmp++;
    if (fetch_resp_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_stale_resp: got resp_valid=%b, required 0", fetch_resp_valid_o);
    end
    cycle(1'b1, 40'h9000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({icache_req_valid_o, buffer_miss_o} !== 2'b11) begin
      n_err++;
      $display("FAIL midreset_rerequest: got valid/miss=%b, required 11",
               {icache_req_valid_o, buffer_miss_o});
    end
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, L2, 1'b0);
    sb.push_back('{vaddr: 40'h9000, data: 32'h11111111, xcpt: 1'b0, cyc: cyc + 1});
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_line_buffer();
    test_kill();
    test_drain();
    test_xcpt();
    test_full();
    test_inval();
    test_midreset();
    idle(3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drained: got %0d pending responses, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_fetch_adapter.md
ICACHE_FETCH_ADAPTER -- requirements
Module: icache_fetch_adapter

Interface
REQ-001 Parameter ADDR_WIDTH, 40, virtual address width in bits.
REQ-002 Parameter LINE_WIDTH, 128, icache response line width in bits; power of two, at least FETCH_WIDTH.
REQ-003 Parameter FETCH_WIDTH, 32, instruction word width returned to fetch; power of two, at least 16.
REQ-004 Parameter QUEUE_DEPTH, 2, maximum outstanding icache requests; power of two, 1 to 8.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 fetch_req_valid_i  in  1  fetch request valid.
REQ-008 fetch_req_vaddr_i  in  ADDR_WIDTH  fetch virtual address, FETCH_WIDTH-aligned.
REQ-009 fetch_req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-010 fetch_kill_i  in  1  flush all outstanding requests (redirect).
REQ-011 fetch_inval_i  in  1  icache invalidate request (fence.i).
REQ-012 fetch_resp_valid_o / fetch_resp_data_o / fetch_resp_vaddr_o / fetch_resp_xcpt_o  out  1 / FETCH_WIDTH / ADDR_WIDTH / 1  response to fetch.
REQ-013 icache_req_valid_o / icache_req_vaddr_o  out  1 / ADDR_WIDTH  icache request; icache_req_ready_i  in  1.
REQ-014 icache_req_kill_o / icache_invalidate_o  out  1 / 1  kill in-flight access; invalidate icache.
REQ-015 icache_resp_valid_i / icache_resp_data_i / icache_resp_xcpt_i  in  1 / LINE_WIDTH / 1  in-order icache response; xcpt = instruction page fault.
REQ-016 buffer_miss_o  out  1  PMU pulse: accepted fetch missed the line buffer.

Function
REQ-017 OFF = log2(LINE_WIDTH/8); word index = vaddr[OFF-1 : log2(FETCH_WIDTH/8)]; tag = vaddr[ADDR_WIDTH-1:OFF].
REQ-018 Outstanding-address FIFO of QUEUE_DEPTH entries; push on icache handshake (icache_req_valid_o & icache_req_ready_i); pop on accepted (non-dropped) icache response.
REQ-019 FSM states: IDLE (FIFO empty, no drop), BUSY (FIFO non-empty), DRAIN (drop count > 0); DRAIN has priority when both apply.
REQ-020 icache_req_valid_o = fetch_req_valid_i & ~fetch_kill_i & ~buffer hit & FIFO not full; icache_req_vaddr_o = fetch_req_vaddr_i.
REQ-021 fetch_req_ready_o = ~fetch_kill_i & (buffer hit | (icache_req_ready_i & FIFO not full)).
REQ-022 Accepted response: fetch_resp_* registered, valid exactly 1 cycle after icache_resp_valid_i; data = selected word of the line; vaddr = FIFO head.
REQ-023 icache_resp_xcpt_i=1: fetch_resp_data_o = 0, fetch_resp_xcpt_o = 1, line not stored in the line buffer.
REQ-024 fetch_kill_i: FIFO cleared; drop count = occupancy (minus 1 if a response arrives that cycle, which is also dropped); icache_req_kill_o = fetch_kill_i; no fetch_resp_valid_o for killed requests.
REQ-025 In DRAIN each icache response decrements the drop count and is discarded; new requests are accepted in DRAIN and their responses are returned after the drop count reaches 0.
REQ-026 icache_invalidate_o = fetch_inval_i (combinational).
REQ-027 icache_resp_valid_i with FIFO empty and drop count 0 is ignored.
REQ-028 buffer_miss_o pulses 1 cycle in the cycle a fetch request is accepted through the icache path; it is 0 otherwise.

Reset
REQ-029 rst_i=1: FIFO empty, drop count 0, FSM IDLE, line buffer invalid; all outputs 0 in the same and next cycle.
REQ-030 rst_i asserted mid-operation discards all outstanding state; icache responses that arrive after reset is released are ignored (REQ-027).

Configuration
REQ-031 Macro ICACHE_LINE_BUFFER_EN defined: one-entry line buffer (valid, tag, LINE_WIDTH data) filled on every accepted non-exception response.
REQ-032 Buffer hit = fetch_req_valid_i & buffer valid & tag match & FIFO empty & drop count 0. A hit is served from the buffer 1 cycle later, with no icache request and no push to the FIFO.
REQ-033 Buffer invalidated on fetch_inval_i or rst_i; fetch_kill_i does not invalidate it.
REQ-034 Macro undefined: no line buffer; buffer hit is constant 0; every accepted fetch is an icache request and pulses buffer_miss_o.

Verification
REQ-035 Reset, then req 0x1008 with icache ready; response line 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> next cycle data 0xCCCCCCCC, vaddr 0x1008, buffer_miss_o=1 at acceptance.
REQ-036 With ICACHE_LINE_BUFFER_EN, after REQ-035 req 0x100C -> no icache_req_valid_o, data 0xDDDDDDDD 1 cycle later, buffer_miss_o=0.
REQ-037 Two back-to-back requests (0x2000, 0x2010), then kill before either response; two responses then arrive -> no fetch_resp_valid_o; next req 0x3000 responds normally.
REQ-038 Response with icache_resp_xcpt_i=1 for 0x4000 -> fetch_resp_xcpt_o=1, data 0; re-request 0x4004 goes to the icache (no buffer hit).
REQ-039 QUEUE_DEPTH=2 with 2 outstanding -> fetch_req_ready_o=0 until a response arrives, and no icache request is issued while the FIFO is full.
REQ-040 fetch_inval_i pulse after a fill -> icache_invalidate_o=1 in the same cycle; re-request of the same line reaches the icache.
